// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: per-register countdown scoreboard for RAW/WAW hazards plus
// a non-pipelined MDU occupancy counter, with stall-cause reporting and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_LAT     = 7,
    parameter int STALL_CNT_W = 32,
    localparam int CW         = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ID_Valid,
    input  logic                   ID_Flush,
    input  logic [REG_ADDR_W-1:0]  ID_Rs,
    input  logic [REG_ADDR_W-1:0]  ID_Rt,
    input  logic                   ID_UseRs,
    input  logic                   ID_UseRt,
    input  logic                   ID_Branch,
    input  logic                   ID_RegWrite,
    input  logic [REG_ADDR_W-1:0]  ID_WriteReg,
    input  logic [CW-1:0]          ID_Latency,
    input  logic                   ID_Mdu,
    output logic                   Stall,
    output logic [1:0]             StallCause,
    output logic [STALL_CNT_W-1:0] StallCount
);

    localparam int NREG = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_RAW  = 2'd1,
        CAUSE_WAW  = 2'd2,
        CAUSE_MDU  = 2'd3
    } cause_e;

    logic [CW-1:0]          cnt_view [NREG];
    logic [CW-1:0]          mdu_occ_q;
    logic [CW-1:0]          mdu_occ_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic                   issue;
    logic                   record_wr;
    logic                   active;
    logic [CW-1:0]          rs_cnt;
    logic [CW-1:0]          rt_cnt;
    logic [CW-1:0]          wr_cnt;
    logic                   raw_rs;
    logic                   raw_rt;
    logic                   raw_hz;
    logic                   waw_hz;
    logic                   mdu_hz;
    cause_e                 cause;

    // Register 0 is hardwired to an empty counter so reads of it never stall.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign cnt_view[gi] = '0;
            end else begin : g_track
                logic [CW-1:0] cnt_q;
                logic [CW-1:0] cnt_d;

                always_comb begin
                    cnt_d = cnt_q;
                    if (record_wr && (ID_WriteReg == REG_ADDR_W'(gi))) begin
                        cnt_d = ID_Latency;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                assign cnt_view[gi] = cnt_q;
            end
        end
    endgenerate

    assign rs_cnt = cnt_view[ID_Rs];
    assign rt_cnt = cnt_view[ID_Rt];
    assign wr_cnt = cnt_view[ID_WriteReg];

    // A count of 1 means the result is forwardable to EX next cycle, but not yet to an ID-stage branch.
    assign raw_rs = ID_UseRs && (ID_Rs != '0) &&
                    (ID_Branch ? (rs_cnt != '0) : (rs_cnt > CW'(1)));
    assign raw_rt = ID_UseRt && (ID_Rt != '0) &&
                    (ID_Branch ? (rt_cnt != '0) : (rt_cnt > CW'(1)));
    assign raw_hz = raw_rs || raw_rt;
    assign waw_hz = ID_RegWrite && (ID_WriteReg != '0) && (wr_cnt > ID_Latency);
    assign mdu_hz = ID_Mdu && (mdu_occ_q > CW'(1));

    assign active    = !reset && ID_Valid && !ID_Flush;
    assign Stall     = active && (raw_hz || waw_hz || mdu_hz);
    assign issue     = active && !Stall;
    assign record_wr = issue && ID_RegWrite && (ID_WriteReg != '0);

    always_comb begin
        cause = CAUSE_NONE;
        if (active) begin
            if (raw_hz) begin
                cause = CAUSE_RAW;
            end else if (waw_hz) begin
                cause = CAUSE_WAW;
            end else if (mdu_hz) begin
                cause = CAUSE_MDU;
            end
        end
    end

    assign StallCause = cause;

    always_comb begin
        mdu_occ_d = mdu_occ_q;
        if (issue && ID_Mdu) begin
            mdu_occ_d = ID_Latency;
        end else if (mdu_occ_q != '0) begin
            mdu_occ_d = mdu_occ_q - 1'b1;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (Stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_occ_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            mdu_occ_q   <= mdu_occ_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: expected Stall/StallCause pushed per driven cycle,
// popped and compared on the falling edge; StallCount checked inline by each scenario.
module tb_hazard_scoreboard;

    localparam int AW = 5;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          ID_Valid, ID_Flush;
    logic [AW-1:0] ID_Rs, ID_Rt, ID_WriteReg;
    logic          ID_UseRs, ID_UseRt, ID_Branch, ID_RegWrite, ID_Mdu;
    logic [CW-1:0] ID_Latency;
    logic          Stall, Stall_s;
    logic [1:0]    StallCause, StallCause_s;
    logic [31:0]   StallCount;
    logic [2:0]    StallCount_s;

    typedef struct {
        string      nm;
        logic       st;
        logic [1:0] cs;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.REG_ADDR_W(AW), .MAX_LAT(7), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Flush(ID_Flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_RegWrite(ID_RegWrite), .ID_WriteReg(ID_WriteReg),
        .ID_Latency(ID_Latency), .ID_Mdu(ID_Mdu),
        .Stall(Stall), .StallCause(StallCause), .StallCount(StallCount)
    );

    // Narrow stall counter instance so saturation is reachable in a short run.
    hazard_scoreboard #(.REG_ADDR_W(AW), .MAX_LAT(7), .STALL_CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .ID_Valid(ID_Valid), .ID_Flush(ID_Flush),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UseRs(ID_UseRs), .ID_UseRt(ID_UseRt),
        .ID_Branch(ID_Branch), .ID_RegWrite(ID_RegWrite), .ID_WriteReg(ID_WriteReg),
        .ID_Latency(ID_Latency), .ID_Mdu(ID_Mdu),
        .Stall(Stall_s), .StallCause(StallCause_s), .StallCount(StallCount_s)
    );

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (Stall !== e.st || StallCause !== e.cs) begin
                n_err++;
                $display("FAIL %s: got Stall=%0b Cause=%0d, required Stall=%0b Cause=%0d",
                         e.nm, Stall, StallCause, e.st, e.cs);
            end else begin
                $display("cycle %s: Stall=%0b Cause=%0d", e.nm, Stall, StallCause);
            end
            if (e.st) exp_count++;
        end
    end

    task automatic drv(input logic v, input logic fl, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic urs, input logic urt, input logic br, input logic rw,
                       input logic [AW-1:0] wr, input logic [CW-1:0] lat, input logic mdu);
        ID_Valid = v;   ID_Flush = fl;   ID_Rs = rs;     ID_Rt = rt;
        ID_UseRs = urs; ID_UseRt = urt;  ID_Branch = br; ID_RegWrite = rw;
        ID_WriteReg = wr; ID_Latency = lat; ID_Mdu = mdu;
    endtask

    task automatic nop();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    task automatic step(input string nm, input logic st, input logic [1:0] cs);
        exp_t e;
        e.nm = nm; e.st = st; e.cs = cs;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        nop();
        @(posedge clk);
        #1;
        drv(1, 0, 5, 5, 1, 1, 1, 1, 5, 7, 1);
        step("reset_hold", 0, 0);
        n_cmp++;
        if (StallCount !== 32'd0) begin
            n_err++;
            $display("FAIL reset_count: got %0d, required 0", StallCount);
        end
        reset = 1'b0;
        nop();
        step("reset_idle", 0, 0);
    endtask

    task automatic test_alu_fwd();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0); step("alu_w_r5", 0, 0);
        drv(1, 0, 5, 0, 1, 0, 0, 1, 6, 1, 0); step("alu_use_r5", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0); step("alu_w_r5_again", 0, 0);
        drv(1, 0, 5, 5, 1, 1, 1, 0, 0, 1, 0); step("beq_r5_stall", 1, 1);
        step("beq_r5_issue", 0, 0);
        nop(); step("alu_nop", 0, 0);
        n_cmp++;
        if (StallCount !== 32'(exp_count)) begin
            n_err++;
            $display("FAIL alu_count: got %0d, required %0d", StallCount, exp_count);
        end
    endtask

    task automatic test_load_use();
        int base;
        base = exp_count;
        drv(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0); step("load_r8", 0, 0);
        drv(1, 0, 8, 0, 1, 0, 0, 1, 10, 1, 0); step("alu_r8_stall", 1, 1);
        step("alu_r8_issue", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0); step("load_r8_again", 0, 0);
        drv(1, 0, 0, 8, 0, 1, 1, 0, 0, 1, 0); step("br_r8_stall1", 1, 1);
        step("br_r8_stall2", 1, 1);
        step("br_r8_issue", 0, 0);
        nop(); step("load_nop", 0, 0);
        n_cmp++;
        if (StallCount !== 32'(base + 3)) begin
            n_err++;
            $display("FAIL load_count: got %0d, required %0d", StallCount, base + 3);
        end
    endtask

    task automatic test_waw();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 6, 1); step("mdu_w_r3", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0);
        for (int i = 0; i < 5; i++) step($sformatf("waw_r3_stall%0d", i), 1, 2);
        step("waw_r3_issue", 0, 0);
        nop(); step("waw_nop", 0, 0);
    endtask

    task automatic test_mdu();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 11, 4, 1); step("mdu1_issue", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 13, 4, 1);
        for (int i = 0; i < 3; i++) step($sformatf("mdu2_stall%0d", i), 1, 3);
        step("mdu2_issue", 0, 0);
        drv(1, 0, 1, 0, 1, 0, 0, 1, 12, 1, 0); step("alu_between", 0, 0);
        drv(1, 0, 13, 0, 1, 0, 0, 1, 14, 4, 1);
        step("mdu3_raw_prio0", 1, 1);
        step("mdu3_raw_prio1", 1, 1);
        step("mdu3_issue", 0, 0);
        nop();
        for (int i = 0; i < 4; i++) step("mdu_drain", 0, 0);
        n_cmp++;
        if (StallCount !== 32'(exp_count)) begin
            n_err++;
            $display("FAIL mdu_count: got %0d, required %0d", StallCount, exp_count);
        end
    endtask

    task automatic test_r0_flush();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0); step("load_r0", 0, 0);
        drv(1, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0); step("br_r0", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 9, 2, 0); step("load_r9", 0, 0);
        drv(1, 1, 9, 0, 1, 0, 1, 1, 9, 7, 0); step("flush_br_r9", 0, 0);
        drv(1, 0, 9, 0, 1, 0, 1, 0, 0, 1, 0); step("br_r9_stall", 1, 1);
        step("br_r9_issue", 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 9, 2, 0); step("load_r9_again", 0, 0);
        drv(0, 0, 9, 0, 1, 0, 1, 0, 0, 1, 0); step("invalid_br_r9", 0, 0);
        nop(); step("flush_nop", 0, 0);
    endtask

    task automatic test_mid_reset();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 4, 7, 1); step("mdu_w_r4", 0, 0);
        reset = 1'b1;
        drv(1, 0, 4, 0, 1, 0, 1, 0, 0, 1, 0); step("reset_mid", 0, 0);
        reset = 1'b0;
        exp_count = 0;
        step("br_r4_after_reset", 0, 0);
        nop(); step("reset_nop", 0, 0);
        n_cmp++;
        if (StallCount !== 32'd0 || StallCount_s !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset_count: got %0d/%0d, required 0/0", StallCount, StallCount_s);
        end
    endtask

    task automatic test_saturation();
        int sat;
        for (int r = 0; r < 2; r++) begin
            drv(1, 0, 0, 0, 0, 0, 0, 1, 20, 7, 0); step("load_r20", 0, 0);
            drv(1, 0, 20, 0, 1, 0, 1, 0, 0, 1, 0);
            for (int i = 0; i < 7; i++) step($sformatf("br_r20_stall%0d", i), 1, 1);
            step("br_r20_issue", 0, 0);
            nop(); step("sat_nop", 0, 0);
            sat = (exp_count > 7) ? 7 : exp_count;
            n_cmp++;
            if (StallCount !== 32'(exp_count)) begin
                n_err++;
                $display("FAIL sat_wide_count: got %0d, required %0d", StallCount, exp_count);
            end
            n_cmp++;
            if (StallCount_s !== 3'(sat)) begin
                n_err++;
                $display("FAIL sat_narrow_count: got %0d, required %0d", StallCount_s, sat);
            end else begin
                $display("count wide=%0d narrow=%0d", StallCount, StallCount_s);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_waw();
        test_mdu();
        test_r0_flush();
        test_mid_reset();
        test_saturation();
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
